// File: rtl/seq_pattern_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_pattern_tx                                                             |
// | Serial pattern transmitter: sends the low len bits MSB-first, rep+1 times. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_rep,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] C_WIDTH_LEN = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic load_ready_q, load_ready_d;
  logic dout_q, dout_d;
  logic dout_valid_q, dout_valid_d;
  logic last_bit_q, last_bit_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] len_m1;

  assign len_clamped = ((load_len == '0) || (load_len > C_WIDTH_LEN)) ? C_WIDTH_LEN : load_len;
  assign len_m1      = len_clamped - LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    rep_d      = rep_q;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          data_d     = load_data;
          rep_d      = load_rep;
          last_idx_d = len_m1[IDX_W-1:0];
          idx_d      = len_m1[IDX_W-1:0];
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == '0) begin
          if (rep_q != '0) begin
            rep_d   = rep_q - REP_W'(1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = last_idx_q;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are derived from the upcoming state so they register in step with it.
    dout_valid_d = (state_d == ST_SHIFT);
    dout_d       = dout_valid_d & data_d[idx_d];
    last_bit_d   = dout_valid_d & (idx_d == '0);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    load_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      last_idx_q   <= '0;
      rep_q        <= '0;
      data_q       <= '0;
      load_ready_q <= 1'b1;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      last_bit_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      rep_q        <= rep_d;
      data_q       <= data_d;
      load_ready_q <= load_ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_bit_q   <= last_bit_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_pattern_tx                                                          |
// | Scoreboard bench for seq_pattern_tx with directed, hand-computed vectors.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic [3:0] load_rep;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       last_bit;
  logic       busy;
  logic       done;

  seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .load_rep   (load_rep),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .last_bit   (last_bit),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // cyc holds the number of the cycle that ends at the next rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic dv;
    logic d;
    logic lb;
    logic dn;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic dv, input logic d, input logic lb, input logic dn);
    exp_t e;
    e.cyc = c; e.dv = dv; e.d = d; e.lb = lb; e.dn = dn;
    q.push_back(e);
  endtask

  task automatic expect_stream(input int first, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++)
      push(first + i, 1'b1, bits[n-1-i], (i == n - 1), 1'b0);
  endtask

  task automatic expect_done(input int c);
    push(c, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pops one expected event for every cycle showing a bit or a done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_event: nothing seen, expected event at cycle %0d (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (dout_valid || done) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got dv=%0b dout=%0b last=%0b done=%0b, expected none (cycle %0d)",
                   dout_valid, dout, last_bit, done, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_bits", int'({dout_valid, dout, last_bit, done}), int'({e.dv, e.d, e.lb, e.dn}));
        end
      end
    end
  end

  // Reference 1001 detector on the serial stream.
  logic [2:0] det_sh  = 3'b000;
  int         det_cnt = 0;
  always @(posedge clk) begin
    if (dout_valid) begin
      if ({det_sh, dout} == 4'b1001) det_cnt <= det_cnt + 1;
      det_sh <= {det_sh[1:0], dout};
    end
  end

  task automatic drive_load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = l;
    load_rep   = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_len = '0; load_rep = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_outputs", int'({dout, dout_valid, last_bit, busy, done}), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single 1001 pattern, len 4, one repetition.
    k = cyc;
    drive_load(8'h09, 4'd4, 4'd0);
    expect_stream(k + 1, 16'b1001, 4);
    expect_done(k + 5);
    @(negedge clk);
    load_valid = 1'b0;
    chk("t1_ready_low", load_ready, 0);
    chk("t1_busy_high", busy, 1);
    wait_until(k + 5);
    chk("t1_ready_at_done", load_ready, 0);
    wait_until(k + 6);
    chk("t1_ready_back", load_ready, 1);
    chk("t1_busy_back", busy, 0);
    chk("t1_detector", det_cnt, 1);
    repeat (2) @(negedge clk);

    // Three repetitions with one-cycle gaps.
    k = cyc;
    drive_load(8'h09, 4'd4, 4'd2);
    expect_stream(k + 1, 16'b1001, 4);
    expect_stream(k + 6, 16'b1001, 4);
    expect_stream(k + 11, 16'b1001, 4);
    expect_done(k + 15);
    @(negedge clk);
    load_valid = 1'b0;
    wait_until(k + 5);
    chk("t2_gap1_busy", busy, 1);
    wait_until(k + 16);
    chk("t2_ready_back", load_ready, 1);
    repeat (2) @(negedge clk);

    // Length clamping: 0 and 15 both mean 8 bits.
    k = cyc;
    drive_load(8'hA5, 4'd0, 4'd0);
    expect_stream(k + 1, 16'b10100101, 8);
    expect_done(k + 9);
    @(negedge clk);
    load_valid = 1'b0;
    wait_until(k + 10);
    chk("t3_len0_ready", load_ready, 1);
    @(negedge clk);
    k = cyc;
    drive_load(8'hA5, 4'd15, 4'd0);
    expect_stream(k + 1, 16'b10100101, 8);
    expect_done(k + 9);
    @(negedge clk);
    load_valid = 1'b0;
    wait_until(k + 10);
    chk("t3_len15_ready", load_ready, 1);
    repeat (2) @(negedge clk);

    // Abort during the second bit, then an immediate new load.
    k = cyc;
    drive_load(8'h09, 4'd4, 4'd0);
    push(k + 1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(k + 2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    load_valid = 1'b0;
    wait_until(k + 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_outputs", int'({dout_valid, busy, load_ready}), 1);
    drive_load(8'h05, 4'd3, 4'd0);
    expect_stream(k + 4, 16'b101, 3);
    expect_done(k + 7);
    @(negedge clk);
    load_valid = 1'b0;
    wait_until(k + 8);
    chk("t4_reload_ready", load_ready, 1);
    repeat (2) @(negedge clk);

    // Reset in a gap, with load_valid held high and different data while busy.
    k = cyc;
    drive_load(8'h09, 4'd4, 4'd2);
    expect_stream(k + 1, 16'b1001, 4);
    @(negedge clk);
    drive_load(8'hFF, 4'd2, 4'd0);
    wait_until(k + 5);
    chk("t5_gap_dv", dout_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", load_ready, 1);
    chk("t5_rst_outputs", int'({dout, dout_valid, last_bit, busy, done}), 0);
    reset = 1'b0;
    load_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Back-to-back loads with load_valid held high.
    k = cyc;
    drive_load(8'h09, 4'd4, 4'd0);
    expect_stream(k + 1, 16'b1001, 4);
    expect_done(k + 5);
    expect_stream(k + 7, 16'b11, 2);
    expect_done(k + 9);
    @(negedge clk);
    drive_load(8'h03, 4'd2, 4'd0);
    wait_until(k + 6);
    chk("t6_ready_gap", load_ready, 1);
    @(negedge clk);
    load_valid = 1'b0;
    chk("t6_second_accepted", load_ready, 0);
    wait_until(k + 10);
    chk("t6_ready_back", load_ready, 1);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
